// File: rtl/huffman_bit_serializer_if.sv
// rtl/huffman_bit_serializer_if.sv - SRAM read port and serial bit stream bundle
interface huffman_bit_serializer_if #(
  parameter int word_bw = 32,
  parameter int addr_bw = 11
);
  logic               mem_cen;
  logic [addr_bw-1:0] mem_addr;
  logic [word_bw-1:0] mem_dout;
  logic               bit_out;
  logic               bit_valid;
  logic               pause;

  modport master (
    output mem_cen, mem_addr, bit_out, bit_valid,
    input  mem_dout, pause
  );

  modport slave (
    input  mem_cen, mem_addr, bit_out, bit_valid,
    output mem_dout, pause
  );
endinterface

// File: rtl/huffman_bit_serializer.sv
// rtl/huffman_bit_serializer.sv - compressed SRAM words to gapless MSB-first bit stream
module huffman_bit_serializer #(
  parameter int word_bw = 32,
  parameter int addr_bw = 11,
  parameter int len_bw  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] base_addr,
  input  logic [len_bw-1:0]  num_bits,
  output logic               busy,
  output logic               done,
  huffman_bit_serializer_if.master bus
);
  localparam int cnt_bw = $clog2(word_bw + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nxt;

  logic [addr_bw-1:0] base;
  logic [len_bw-1:0]  bits_left;
  logic [len_bw-1:0]  words_fetched;
  logic [len_bw:0]    words_total;
  logic [len_bw:0]    words_needed;
  logic [word_bw-1:0] shreg;
  logic [word_bw-1:0] hold;
  logic [cnt_bw-1:0]  sh_cnt;
  logic               hold_valid;
  logic               outstanding;

  logic       sh_nonempty;
  logic       xfer;
  logic       issue;
  logic       sh_empties;
  logic       last_bit;
  logic [1:0] slots_used;

  always_comb begin
    words_needed = ({1'b0, num_bits} + (len_bw+1)'(word_bw - 1)) / (len_bw+1)'(word_bw);
    sh_nonempty  = (sh_cnt != '0);
    // An in-flight read already owns a slot, so the hold register can never overflow.
    slots_used   = {1'b0, sh_nonempty} + {1'b0, hold_valid} + {1'b0, outstanding};
    issue        = (state == RUN) && ({1'b0, words_fetched} < words_total) && (slots_used < 2'd2);
    xfer         = (state == RUN) && sh_nonempty && !bus.pause && (bits_left != '0);
    sh_empties   = !sh_nonempty || (xfer && (sh_cnt == cnt_bw'(1)));
    last_bit     = xfer && (bits_left == len_bw'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (num_bits == '0) ? FIN : RUN;
      RUN:  if (last_bit) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_cen   = ~issue;
    bus.mem_addr  = base + addr_bw'(words_fetched);
    bus.bit_out   = shreg[word_bw-1];
    bus.bit_valid = xfer;
    busy          = (state == RUN);
    done          = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base          <= '0;
      bits_left     <= '0;
      words_fetched <= '0;
      words_total   <= '0;
      shreg         <= '0;
      hold          <= '0;
      sh_cnt        <= '0;
      hold_valid    <= 1'b0;
      outstanding   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base          <= base_addr;
            bits_left     <= num_bits;
            words_total   <= words_needed;
            words_fetched <= '0;
            shreg         <= '0;
            sh_cnt        <= '0;
            hold_valid    <= 1'b0;
            outstanding   <= 1'b0;
          end
        end
        RUN: begin
          outstanding <= issue;
          if (issue) words_fetched <= words_fetched + len_bw'(1);
          if (xfer)  bits_left <= bits_left - len_bw'(1);
          // Returning data takes the shift register whenever it is (or is becoming) empty.
          if (outstanding && sh_empties) begin
            shreg  <= bus.mem_dout;
            sh_cnt <= cnt_bw'(word_bw);
          end else if (xfer && (sh_cnt == cnt_bw'(1)) && hold_valid) begin
            shreg      <= hold;
            sh_cnt     <= cnt_bw'(word_bw);
            hold_valid <= 1'b0;
          end else if (xfer) begin
            shreg  <= {shreg[word_bw-2:0], 1'b0};
            sh_cnt <= sh_cnt - cnt_bw'(1);
          end
          if (outstanding && !sh_empties) begin
            hold       <= bus.mem_dout;
            hold_valid <= 1'b1;
          end
        end
        FIN: begin
          outstanding <= 1'b0;
          sh_cnt      <= '0;
          hold_valid  <= 1'b0;
        end
        default: begin
          outstanding <= 1'b0;
        end
      endcase
    end
  end
endmodule
